// File: rtl/axis_frame_gen_pkg.sv
// Shared state encoding and byte-pattern helper for axis_frame_gen.
package axis_frame_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte lane value of a beat; 8-bit arithmetic gives the mod-256 wrap for free.
  function automatic logic [7:0] pattern_byte(input logic [7:0] seed,
                                              input logic [7:0] beat,
                                              input logic [7:0] keep_width,
                                              input logic [7:0] lane);
    return seed + beat * keep_width + lane;
  endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// AXI-Stream test-frame generator with an incrementing byte pattern.
// Bad-frame tuser marking is built only when AXIS_FRAME_GEN_BAD_FRAME_EN is defined.
//
// state | meaning
// IDLE  | waiting for an accepted cfg_start
// SEND  | streaming frames of the latched configuration
// DONE  | one-cycle completion pulse, then back to IDLE
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_count,
  input  logic [7:0]            cfg_seed,
  input  logic [LEN_WIDTH-1:0]  cfg_bad_interval,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  status_busy,
  output logic                  status_done,
  output logic [LEN_WIDTH-1:0]  status_frames_sent
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_count;
  logic [LEN_WIDTH-1:0]  r_beat;
  logic [LEN_WIDTH-1:0]  r_frames;
  logic [7:0]            r_seed;
  logic                  r_stop_pend;
  logic                  w_start;
  logic                  w_hs;
  logic                  w_last;
  logic                  w_last_hs;
  logic                  w_final;
  logic [DATA_WIDTH-1:0] w_pattern;

  assign w_start   = (r_state == IDLE) && cfg_start && (cfg_frame_len != '0);
  assign w_hs      = m_axis_tvalid && m_axis_tready;
  assign w_last    = (r_state == SEND) && (r_beat == r_len - LEN_ONE);
  assign w_last_hs = w_hs && w_last;
  // A stop arriving with the tlast handshake still ends the run on this frame.
  assign w_final   = ((r_count != '0) && ((r_frames + LEN_ONE) == r_count)) ||
                     r_stop_pend || cfg_stop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = SEND;
      SEND:    if (w_last_hs && w_final) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len   <= '0;
      r_count <= '0;
      r_seed  <= '0;
    end else if (w_start) begin
      r_len   <= cfg_frame_len;
      r_count <= cfg_frame_count;
      r_seed  <= cfg_seed;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat      <= '0;
      r_frames    <= '0;
      r_stop_pend <= 1'b0;
    end else if (w_start) begin
      r_beat      <= '0;
      r_frames    <= '0;
      r_stop_pend <= 1'b0;
    end else if (r_state == SEND) begin
      if (cfg_stop) r_stop_pend <= 1'b1;
      if (w_hs) begin
        if (w_last) begin
          r_beat   <= '0;
          r_frames <= r_frames + LEN_ONE;
        end else begin
          r_beat <= r_beat + LEN_ONE;
        end
      end
    end else begin
      r_stop_pend <= 1'b0;
    end
  end

  for (genvar l = 0; l < KEEP_WIDTH; l++) begin : g_lane
    assign w_pattern[8*l +: 8] = pattern_byte(r_seed, r_beat[7:0], 8'(KEEP_WIDTH), 8'(l));
  end

  assign m_axis_tvalid      = (r_state == SEND);
  assign m_axis_tdata       = m_axis_tvalid ? w_pattern : '0;
  assign m_axis_tkeep       = '1;
  assign m_axis_tlast       = w_last;
  assign status_busy        = (r_state == SEND);
  assign status_done        = (r_state == DONE);
  assign status_frames_sent = r_frames;

`ifdef AXIS_FRAME_GEN_BAD_FRAME_EN
  logic [LEN_WIDTH-1:0] r_bad_interval;
  logic [LEN_WIDTH-1:0] r_bad_left;

  // Frames remaining until the next bad one; reaching 1 marks the current frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bad_interval <= '0;
      r_bad_left     <= '0;
    end else if (w_start) begin
      r_bad_interval <= cfg_bad_interval;
      r_bad_left     <= cfg_bad_interval;
    end else if (w_last_hs) begin
      r_bad_left <= (r_bad_left == LEN_ONE) ? r_bad_interval : r_bad_left - LEN_ONE;
    end
  end

  assign m_axis_tuser = w_last && (r_bad_interval != '0) && (r_bad_left == LEN_ONE);
`else
  logic w_unused_bad_interval;
  assign w_unused_bad_interval = ^cfg_bad_interval;
  assign m_axis_tuser          = 1'b0;
`endif

endmodule
